alu_rle: RTL and testbench

Run-length cell ALU for the bf-cpu datapath, the parametrised successor to the single-step `alu` (nochange/decrement/increment). It accepts one operation per transaction: a cell value, an opcode and a repeat count (collapsed `+++`/`---` runs). It applies one ±1 step per clock, in wrap or saturate mode. The result goes to the cell write-back path, with a zero flag for loop-bracket decisions. Both input and output use valid/ready handshakes.

---
 rtl/alu_rle_if.sv | 27 ++
 rtl/alu_rle.sv | 140 ++++++++++++++
 tb/tb_alu_rle.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rle_if.sv
// Handshake bundle for the run-length cell ALU: request channel (cell, opcode, count)
// and result channel (value plus zero/overflow flags).
interface alu_rle_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [1:0]       in_op;
    logic [CNT_W-1:0] in_count;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             out_zero;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_op, in_count, out_ready,
        input  in_ready, out_valid, out, out_zero, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_op, in_count, out_ready,
        output in_ready, out_valid, out, out_zero, out_ovf
    );
endinterface

// File: rtl/alu_rle.sv
// Run-length cell ALU: applies one +/-1 step per clock for a collapsed +++/--- run,
// in wrap or saturate mode, and presents the result with zero/overflow flags.
module alu_rle #(
    parameter int WIDTH    = 8,
    parameter int CNT_W    = 4,
    parameter int SATURATE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_rle_if.slave   bus
);
    localparam logic [1:0]       OP_NOP  = 2'b00;
    localparam logic [1:0]       OP_INC  = 2'b10;
    localparam logic [1:0]       OP_CLR  = 2'b11;
    localparam logic [WIDTH-1:0] VAL_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] VAL_MIN = {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] CNT_0   = {CNT_W{1'b0}};

    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] acc_r, acc_s;
    logic [CNT_W-1:0] rem_r, rem_s;
    logic [1:0]       op_r, op_s;
    logic             ovf_r, ovf_s;
    logic             in_ready_r, out_valid_r, zero_r;

    logic [WIDTH-1:0] step_src_s, step_lim_s, step_val_s;
    logic [CNT_W-1:0] step_left_s;
    logic             step_up_s, step_ovf_s, step_stop_s;

    // Single-step unit: the accept edge steps from in_a, BUSY edges step from acc.
    // In saturate mode a step landing on the limit with steps still pending ends the
    // run at once, since every remaining step would be discarded anyway.
    always_comb begin
        if (state_r == IDLE) begin
            step_src_s  = bus.in_a;
            step_up_s   = (bus.in_op == OP_INC);
            step_left_s = bus.in_count - CNT_W'(1);
        end else begin
            step_src_s  = acc_r;
            step_up_s   = (op_r == OP_INC);
            step_left_s = rem_r - CNT_W'(1);
        end
        step_lim_s  = step_up_s ? VAL_MAX : VAL_MIN;
        step_val_s  = step_up_s ? step_src_s + WIDTH'(1) : step_src_s - WIDTH'(1);
        step_ovf_s  = 1'b0;
        step_stop_s = (step_left_s == CNT_0);
        if (step_src_s == step_lim_s) begin
            step_ovf_s = 1'b1;
            if (SATURATE != 0) begin
                step_val_s  = step_src_s;
                step_stop_s = 1'b1;
            end else begin
                step_stop_s = (step_left_s == CNT_0);
            end
        end else if ((SATURATE != 0) && (step_val_s == step_lim_s) && (step_left_s != CNT_0)) begin
            step_ovf_s  = 1'b1;
            step_stop_s = 1'b1;
        end else begin
            step_ovf_s = 1'b0;
        end
    end

    // Next-state and datapath update for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        rem_s   = rem_r;
        op_s    = op_r;
        ovf_s   = ovf_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    op_s    = bus.in_op;
                    ovf_s   = 1'b0;
                    rem_s   = CNT_0;
                    state_s = DONE;
                    if (bus.in_op == OP_CLR) begin
                        acc_s = VAL_MIN;
                    end else if ((bus.in_op == OP_NOP) || (bus.in_count == CNT_0)) begin
                        acc_s = bus.in_a;
                    end else begin
                        acc_s   = step_val_s;
                        ovf_s   = step_ovf_s;
                        rem_s   = step_left_s;
                        state_s = step_stop_s ? DONE : BUSY;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                acc_s   = step_val_s;
                ovf_s   = ovf_r | step_ovf_s;
                rem_s   = step_left_s;
                state_s = step_stop_s ? DONE : BUSY;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State/datapath registers; handshake and flag outputs are registered from next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            acc_r       <= VAL_MIN;
            rem_r       <= CNT_0;
            op_r        <= OP_NOP;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            zero_r      <= 1'b1;
        end else begin
            state_r     <= state_s;
            acc_r       <= acc_s;
            rem_r       <= rem_s;
            op_r        <= op_s;
            ovf_r       <= ovf_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
            zero_r      <= (acc_s == VAL_MIN);
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out       = acc_r;
    assign bus.out_zero  = zero_r;
    assign bus.out_ovf   = ovf_r;
endmodule

// File: tb/tb_alu_rle.sv
// Bench for alu_rle: a wrap-mode and a saturate-mode instance driven with identical
// directed vectors, checked every cycle against an arithmetic model of a run.
module tb_alu_rle;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_rle_if #(.WIDTH(8), .CNT_W(4)) if0 ();
    alu_rle_if #(.WIDTH(8), .CNT_W(4)) if1 ();

    alu_rle #(.WIDTH(8), .CNT_W(4), .SATURATE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    alu_rle #(.WIDTH(8), .CNT_W(4), .SATURATE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    typedef struct {
        logic [7:0] r;
        bit         ov;
        int         lat;
        int         acc;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [1:0] op;
        logic [3:0] n;
        logic [7:0] r0;
        bit         o0;
        int         l0;
        logic [7:0] r1;
        bit         o1;
        int         l1;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    bit   seen[2];
    bit   ready_chk[2];
    int   last_hs[2];
    vec_t tbl[12];

    task automatic chk(input int d, input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL dut%0d %s: got %0h required %0h (cycle %0d)", d, nm, act, req, cyc);
        end
    endtask

    // Whole-run arithmetic: exact sum, then wrap or clamp; saturate stops once the limit is reached.
    function automatic void model(input bit sat, input logic [7:0] a, input logic [1:0] op,
                                  input logic [3:0] n, output logic [7:0] r, output bit ov,
                                  output int lat);
        int v;
        ov  = 1'b0;
        lat = 1;
        if (op == 2'b11) begin
            r = 8'h00;
        end else if (op == 2'b00 || n == 4'd0) begin
            r = a;
        end else begin
            v   = (op == 2'b10) ? int'(a) + int'(n) : int'(a) - int'(n);
            ov  = (v > 255) || (v < 0);
            lat = int'(n);
            r   = v[7:0];
            if (sat && ov) begin
                r   = (v > 255) ? 8'hFF : 8'h00;
                lat = (op == 2'b10) ? 255 - int'(a) : int'(a);
                if (lat == 0) lat = 1;
            end
        end
    endfunction

    task automatic mon(input int d, input logic ov, input logic ir, input logic ordy,
                       input logic [7:0] o, input logic oz, input logic oo);
        exp_t e;
        int   qs;
        if (ready_chk[d]) begin
            chk(d, "in_ready_after_hs", int'(ir), 1);
            chk(d, "out_valid_after_hs", int'(ov), 0);
            ready_chk[d] = 1'b0;
        end
        if (ov) begin
            qs = (d == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
                chk(d, "unexpected_out_valid", 1, 0);
            end else begin
                e = (d == 0) ? q0[0] : q1[0];
                chk(d, "out", int'(o), int'(e.r));
                chk(d, "out_zero", int'(oz), int'(e.r == 8'h00));
                chk(d, "out_ovf", int'(oo), int'(e.ov));
                chk(d, "in_ready_in_done", int'(ir), 0);
                if (!seen[d]) begin
                    chk(d, "latency", cyc - e.acc, e.lat);
                    seen[d] = 1'b1;
                end
                if (ordy) begin
                    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    seen[d]      = 1'b0;
                    ready_chk[d] = 1'b1;
                    last_hs[d]   = cyc;
                end
            end
        end
    endtask

    // The compare process: both instances checked on every falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, if0.out_valid, if0.in_ready, if0.out_ready, if0.out, if0.out_zero, if0.out_ovf);
            mon(1, if1.out_valid, if1.in_ready, if1.out_ready, if1.out, if1.out_zero, if1.out_ovf);
        end
    end

    task automatic drive_in(input logic v, input logic [7:0] a, input logic [1:0] op, input logic [3:0] n);
        if0.in_valid = v; if0.in_a = a; if0.in_op = op; if0.in_count = n;
        if1.in_valid = v; if1.in_a = a; if1.in_op = op; if1.in_count = n;
    endtask

    task automatic set_ready(input logic r);
        if0.out_ready = r;
        if1.out_ready = r;
    endtask

    task automatic issue(input vec_t v, input bit gap);
        int         w;
        exp_t       e;
        logic [7:0] mr;
        bit         mo;
        int         ml;
        w = 0;
        while (!(if0.in_ready && if1.in_ready) && w < 64) begin
            @(negedge clk);
            w++;
        end
        if (w >= 64) begin
            chk(0, "timeout_in_ready", 0, 1);
            return;
        end
        model(1'b0, v.a, v.op, v.n, mr, mo, ml);
        chk(0, "model_res", int'(mr), int'(v.r0));
        chk(0, "model_ovf", int'(mo), int'(v.o0));
        chk(0, "model_lat", ml, v.l0);
        e.r = mr; e.ov = mo; e.lat = ml; e.acc = cyc;
        q0.push_back(e);
        model(1'b1, v.a, v.op, v.n, mr, mo, ml);
        chk(1, "model_res", int'(mr), int'(v.r1));
        chk(1, "model_ovf", int'(mo), int'(v.o1));
        chk(1, "model_lat", ml, v.l1);
        e.r = mr; e.ov = mo; e.lat = ml; e.acc = cyc;
        q1.push_back(e);
        if (gap) chk(0, "b2b_accept_gap", cyc - last_hs[0], 1);
        drive_in(1'b1, v.a, v.op, v.n);
        @(negedge clk);
        drive_in(1'b0, 8'($urandom), 2'($urandom), 4'($urandom));
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q0.size() != 0 || q1.size() != 0) && w < 64) begin
            @(negedge clk);
            w++;
        end
        if (w >= 64) chk(0, "timeout_drain", 0, 1);
        @(negedge clk);
    endtask

    task automatic chk_idle(input string nm);
        chk(0, {nm, "_in_ready"}, int'(if0.in_ready), 1);
        chk(0, {nm, "_out_valid"}, int'(if0.out_valid), 0);
        chk(0, {nm, "_out"}, int'(if0.out), 0);
        chk(0, {nm, "_out_zero"}, int'(if0.out_zero), 1);
        chk(0, {nm, "_out_ovf"}, int'(if0.out_ovf), 0);
        chk(1, {nm, "_in_ready"}, int'(if1.in_ready), 1);
        chk(1, {nm, "_out_valid"}, int'(if1.out_valid), 0);
        chk(1, {nm, "_out"}, int'(if1.out), 0);
        chk(1, {nm, "_out_zero"}, int'(if1.out_zero), 1);
        chk(1, {nm, "_out_ovf"}, int'(if1.out_ovf), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //            a      op     n      wrap: res   ovf   lat  sat: res   ovf   lat
        tbl[0]  = '{8'hAD, 2'b00, 4'd3,  8'hAD, 1'b0, 1,  8'hAD, 1'b0, 1};
        tbl[1]  = '{8'hAD, 2'b01, 4'd1,  8'hAC, 1'b0, 1,  8'hAC, 1'b0, 1};
        tbl[2]  = '{8'hAD, 2'b10, 4'd1,  8'hAE, 1'b0, 1,  8'hAE, 1'b0, 1};
        tbl[3]  = '{8'hFE, 2'b10, 4'd3,  8'h01, 1'b1, 3,  8'hFF, 1'b1, 1};
        tbl[4]  = '{8'h02, 2'b01, 4'd2,  8'h00, 1'b0, 2,  8'h00, 1'b0, 2};
        tbl[5]  = '{8'h5A, 2'b11, 4'd7,  8'h00, 1'b0, 1,  8'h00, 1'b0, 1};
        tbl[6]  = '{8'hFD, 2'b10, 4'd5,  8'h02, 1'b1, 5,  8'hFF, 1'b1, 2};
        tbl[7]  = '{8'hFD, 2'b10, 4'd2,  8'hFF, 1'b0, 2,  8'hFF, 1'b0, 2};
        tbl[8]  = '{8'h01, 2'b01, 4'd15, 8'hF2, 1'b1, 15, 8'h00, 1'b1, 1};
        tbl[9]  = '{8'h00, 2'b01, 4'd1,  8'hFF, 1'b1, 1,  8'h00, 1'b1, 1};
        tbl[10] = '{8'h33, 2'b10, 4'd0,  8'h33, 1'b0, 1,  8'h33, 1'b0, 1};
        tbl[11] = '{8'h80, 2'b10, 4'd15, 8'h8F, 1'b0, 15, 8'h8F, 1'b0, 15};
        last_hs[0] = -100;
        last_hs[1] = -100;

        drive_in(1'b0, 8'h00, 2'b00, 4'd0);
        set_ready(1'b1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            issue(tbl[i], 1'b0);
            drain();
        end

        // Back-to-back with out_ready held high.
        v = '{8'h10, 2'b10, 4'd1, 8'h11, 1'b0, 1, 8'h11, 1'b0, 1};
        issue(v, 1'b0);
        v = '{8'h20, 2'b01, 4'd2, 8'h1E, 1'b0, 2, 8'h1E, 1'b0, 2};
        issue(v, 1'b1);
        v = '{8'h30, 2'b00, 4'd9, 8'h30, 1'b0, 1, 8'h30, 1'b0, 1};
        issue(v, 1'b1);
        drain();

        // Backpressure: result held while out_ready is low; a stray request is ignored.
        set_ready(1'b0);
        v = '{8'h10, 2'b10, 4'd4, 8'h14, 1'b0, 4, 8'h14, 1'b0, 4};
        issue(v, 1'b0);
        for (int k = 0; k < 9; k++) begin
            if (k == 7) drive_in(1'b1, 8'h77, 2'b10, 4'd1);
            else        drive_in(1'b0, 8'h77, 2'b10, 4'd1);
            @(negedge clk);
        end
        drive_in(1'b0, 8'h00, 2'b00, 4'd0);
        chk(0, "hold_out_valid", int'(if0.out_valid), 1);
        chk(0, "hold_in_ready", int'(if0.in_ready), 0);
        set_ready(1'b1);
        drain();

        // Reset in the third BUSY cycle discards the run.
        v = '{8'h00, 2'b10, 4'd15, 8'h0F, 1'b0, 15, 8'h0F, 1'b0, 15};
        issue(v, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q0.delete();
        q1.delete();
        seen[0] = 1'b0;
        seen[1] = 1'b0;
        chk_idle("midreset");
        v = '{8'h07, 2'b10, 4'd1, 8'h08, 1'b0, 1, 8'h08, 1'b0, 1};
        issue(v, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
